// File: rtl/taillight_monitor_if.sv
// Light bus and status outputs shared between a carFSM-side driver and the taillight monitor.
// The master drives the lights and control strobes; the slave (monitor) returns the sweep status.
interface taillight_monitor_if #(
    parameter int CW = 8
);
    logic          sample_en;
    logic          clear;
    logic          la;
    logic          lb;
    logic          lc;
    logic          ra;
    logic          rb;
    logic          rc;
    logic          dir_left;
    logic          dir_right;
    logic          sweep_done;
    logic          sweep_left;
    logic [CW-1:0] left_count;
    logic [CW-1:0] right_count;
    logic          err;
    logic [1:0]    err_code;
    logic          err_sticky;

    modport master (
        output sample_en, clear, la, lb, lc, ra, rb, rc,
        input  dir_left, dir_right, sweep_done, sweep_left,
               left_count, right_count, err, err_code, err_sticky
    );

    modport slave (
        input  sample_en, clear, la, lb, lc, ra, rb, rc,
        output dir_left, dir_right, sweep_done, sweep_left,
               left_count, right_count, err, err_code, err_sticky
    );
endinterface

// File: rtl/taillight_monitor.sv
// Taillight sequence checker: tracks left/right sweeps from carFSM lights, counts completed
// sweeps with saturation and flags illegal or out-of-order patterns.
module taillight_monitor #(
    parameter int CW          = 8,
    parameter int ALLOW_ABORT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    taillight_monitor_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_RESYNC
    } state_t;

    typedef enum logic [2:0] {
        P_OFF, P_L1, P_L2, P_L3, P_R1, P_R2, P_R3, P_ILL
    } pat_t;

    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic          ABORT_ERR = (ALLOW_ABORT == 0) ? 1'b1 : 1'b0;

    // Pattern order is {lc,lb,la,ra,rb,rc}; anything not listed is illegal.
    function automatic pat_t decode(input logic [5:0] p);
        pat_t r;
        case (p)
            6'b000000: r = P_OFF;
            6'b001000: r = P_L1;
            6'b011000: r = P_L2;
            6'b111000: r = P_L3;
            6'b000100: r = P_R1;
            6'b000110: r = P_R2;
            6'b000111: r = P_R3;
            default:   r = P_ILL;
        endcase
        return r;
    endfunction

    state_t        state_r;
    state_t        state_nxt;
    pat_t          pat_s;
    logic          done_s;
    logic          done_left_s;
    logic          err_s;
    logic [1:0]    code_s;

    logic          dir_left_r;
    logic          dir_right_r;
    logic          sweep_done_r;
    logic          sweep_left_r;
    logic [CW-1:0] left_count_r;
    logic [CW-1:0] right_count_r;
    logic          err_r;
    logic [1:0]    err_code_r;
    logic          err_sticky_r;

    assign pat_s = decode({bus.lc, bus.lb, bus.la, bus.ra, bus.rb, bus.rc});

    // Next-state and event decode for one enabled sample.
    always_comb begin
        state_nxt   = state_r;
        done_s      = 1'b0;
        done_left_s = 1'b0;
        err_s       = 1'b0;
        code_s      = 2'd0;
        if (bus.sample_en) begin
            if ((pat_s == P_ILL) && (state_r != S_RESYNC)) begin
                err_s     = 1'b1;
                code_s    = 2'd1;
                state_nxt = S_RESYNC;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        case (pat_s)
                            P_OFF:   state_nxt = S_IDLE;
                            P_L1:    state_nxt = S_L1;
                            P_R1:    state_nxt = S_R1;
                            default: begin err_s = 1'b1; code_s = 2'd2; state_nxt = S_RESYNC; end
                        endcase
                    end
                    S_L1, S_L2, S_R1, S_R2: begin
                        if (pat_s == P_OFF) begin
                            // Mid-sweep return to off: abort, optionally reported.
                            state_nxt = S_IDLE;
                            err_s     = ABORT_ERR;
                            code_s    = ABORT_ERR ? 2'd3 : 2'd0;
                        end else if ((state_r == S_L1 && pat_s == P_L2) ||
                                     (state_r == S_R1 && pat_s == P_R2)) begin
                            state_nxt = (state_r == S_L1) ? S_L2 : S_R2;
                        end else if ((state_r == S_L2 && pat_s == P_L3) ||
                                     (state_r == S_R2 && pat_s == P_R3)) begin
                            state_nxt = (state_r == S_L2) ? S_L3 : S_R3;
                        end else begin
                            err_s     = 1'b1;
                            code_s    = 2'd2;
                            state_nxt = S_RESYNC;
                        end
                    end
                    S_L3, S_R3: begin
                        if (pat_s == P_OFF) begin
                            state_nxt   = S_IDLE;
                            done_s      = 1'b1;
                            done_left_s = (state_r == S_L3) ? 1'b1 : 1'b0;
                        end else begin
                            err_s     = 1'b1;
                            code_s    = 2'd2;
                            state_nxt = S_RESYNC;
                        end
                    end
                    S_RESYNC: begin
                        state_nxt = (pat_s == P_OFF) ? S_IDLE : S_RESYNC;
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end else begin
            state_nxt = state_r;
        end
    end

    // State and registered outputs; clear wins over same-cycle increment or sticky set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= S_IDLE;
            dir_left_r    <= 1'b0;
            dir_right_r   <= 1'b0;
            sweep_done_r  <= 1'b0;
            sweep_left_r  <= 1'b0;
            left_count_r  <= {CW{1'b0}};
            right_count_r <= {CW{1'b0}};
            err_r         <= 1'b0;
            err_code_r    <= 2'd0;
            err_sticky_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            dir_left_r   <= (state_nxt == S_L1) || (state_nxt == S_L2) || (state_nxt == S_L3);
            dir_right_r  <= (state_nxt == S_R1) || (state_nxt == S_R2) || (state_nxt == S_R3);
            sweep_done_r <= done_s;
            err_r        <= err_s;
            if (done_s) begin
                sweep_left_r <= done_left_s;
            end
            if (err_s) begin
                err_code_r <= code_s;
            end
            if (bus.clear) begin
                left_count_r  <= {CW{1'b0}};
                right_count_r <= {CW{1'b0}};
                err_sticky_r  <= 1'b0;
            end else begin
                if (done_s && done_left_s && (left_count_r != CNT_MAX)) begin
                    left_count_r <= left_count_r + {{(CW-1){1'b0}}, 1'b1};
                end
                if (done_s && !done_left_s && (right_count_r != CNT_MAX)) begin
                    right_count_r <= right_count_r + {{(CW-1){1'b0}}, 1'b1};
                end
                if (err_s) begin
                    err_sticky_r <= 1'b1;
                end
            end
        end
    end

    assign bus.dir_left    = dir_left_r;
    assign bus.dir_right   = dir_right_r;
    assign bus.sweep_done  = sweep_done_r;
    assign bus.sweep_left  = sweep_left_r;
    assign bus.left_count  = left_count_r;
    assign bus.right_count = right_count_r;
    assign bus.err         = err_r;
    assign bus.err_code    = err_code_r;
    assign bus.err_sticky  = err_sticky_r;
endmodule

// File: tb/tb_taillight_monitor.sv
// Bench for taillight_monitor: two instances (default, and CW=2 with aborts as errors) share one
// stimulus stream; a directed table, hand sequences and random traffic are checked against a model.
module tb_taillight_monitor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    taillight_monitor_if #(.CW(8)) bus0 ();
    taillight_monitor_if #(.CW(2)) bus1 ();

    taillight_monitor #(.CW(8), .ALLOW_ABORT(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    taillight_monitor #(.CW(2), .ALLOW_ABORT(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int checks = 0;
    int passed = 0;

    // Reference model: which side is sweeping, how many lamps that side has reached, resync flag.
    int m_side[2], m_pos[2], m_resync[2];
    int m_done[2], m_sl[2], m_lc[2], m_rc[2], m_err[2], m_code[2], m_sticky[2];
    int m_max[2] = '{255, 3};
    int m_aa[2]  = '{1, 0};

    typedef struct {
        logic [5:0] pat;
        logic       en;
        logic       clr;
        logic       dl;
        logic       dr;
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [7:0] lcnt;
        logic [7:0] rcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [5:0] p, logic en, logic clr, logic dl, logic dr, logic dn,
                                logic er, logic [1:0] cd, logic [7:0] lc, logic [7:0] rc);
        vec_t v;
        v.pat = p; v.en = en; v.clr = clr; v.dl = dl; v.dr = dr; v.done = dn;
        v.err = er; v.code = cd; v.lcnt = lc; v.rcnt = rc;
        return v;
    endfunction

    function automatic int pop3(logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    // A side is legal when its lamps are lit contiguously from the innermost one.
    function automatic bit thermo(logic [2:0] v);
        int x;
        x = int'(v);
        return (x & (x + 1)) == 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_side[i] = 0; m_pos[i] = 0; m_resync[i] = 0; m_done[i] = 0; m_sl[i] = 0;
            m_lc[i] = 0; m_rc[i] = 0; m_err[i] = 0; m_code[i] = 0; m_sticky[i] = 0;
        end
    endtask

    task automatic model_step(int i, logic [5:0] p, logic en, logic clr);
        logic [2:0] lv, rv;
        int nl, nr, s, k, prev;
        bit legal, off;
        lv    = p[5:3];
        rv    = {p[0], p[1], p[2]};
        nl    = pop3(lv);
        nr    = pop3(rv);
        legal = thermo(lv) && thermo(rv) && !(nl > 0 && nr > 0);
        off   = (nl == 0) && (nr == 0);
        m_done[i] = 0;
        m_err[i]  = 0;
        if (en) begin
            prev = m_side[i];
            if (m_resync[i] != 0) begin
                if (legal && off) m_resync[i] = 0;
            end else if (!legal) begin
                m_err[i] = 1; m_code[i] = 1; m_resync[i] = 1; m_side[i] = 0; m_pos[i] = 0;
            end else if (off) begin
                if (prev != 0 && m_pos[i] == 3) begin
                    m_done[i] = 1;
                    m_sl[i]   = (prev == 1) ? 1 : 0;
                    if (prev == 1) m_lc[i] = (m_lc[i] < m_max[i]) ? m_lc[i] + 1 : m_max[i];
                    else           m_rc[i] = (m_rc[i] < m_max[i]) ? m_rc[i] + 1 : m_max[i];
                end else if (prev != 0 && m_aa[i] == 0) begin
                    m_err[i] = 1; m_code[i] = 3;
                end
                m_side[i] = 0; m_pos[i] = 0;
            end else begin
                s = (nl > 0) ? 1 : 2;
                k = (nl > 0) ? nl : nr;
                if ((prev == 0 && k == 1) || (prev == s && k == m_pos[i] + 1)) begin
                    m_side[i] = s; m_pos[i] = k;
                end else begin
                    m_err[i] = 1; m_code[i] = 2; m_resync[i] = 1; m_side[i] = 0; m_pos[i] = 0;
                end
            end
        end
        if (clr) begin
            m_lc[i] = 0; m_rc[i] = 0; m_sticky[i] = 0;
        end else if (m_err[i] != 0) begin
            m_sticky[i] = 1;
        end
    endtask

    task automatic read_out(input int i, output int dl, output int dr, output int dn, output int sl,
                            output int lc, output int rc, output int er, output int cd, output int st);
        if (i == 0) begin
            dl = int'(bus0.dir_left);   dr = int'(bus0.dir_right); dn = int'(bus0.sweep_done);
            sl = int'(bus0.sweep_left); lc = int'(bus0.left_count); rc = int'(bus0.right_count);
            er = int'(bus0.err);        cd = int'(bus0.err_code);   st = int'(bus0.err_sticky);
        end else begin
            dl = int'(bus1.dir_left);   dr = int'(bus1.dir_right); dn = int'(bus1.sweep_done);
            sl = int'(bus1.sweep_left); lc = int'(bus1.left_count); rc = int'(bus1.right_count);
            er = int'(bus1.err);        cd = int'(bus1.err_code);   st = int'(bus1.err_sticky);
        end
    endtask

    task automatic check_model(int i, string tag);
        int dl, dr, dn, sl, lc, rc, er, cd, st;
        int edl, edr;
        read_out(i, dl, dr, dn, sl, lc, rc, er, cd, st);
        edl = (m_side[i] == 1) ? 1 : 0;
        edr = (m_side[i] == 2) ? 1 : 0;
        checks++;
        if (dl == edl && dr == edr && dn == m_done[i] && sl == m_sl[i] && lc == m_lc[i] &&
            rc == m_rc[i] && er == m_err[i] && cd == m_code[i] && st == m_sticky[i]) begin
            passed++;
        end else begin
            $display("FAIL model_%s dut%0d t=%0t got dl=%0d dr=%0d done=%0d sl=%0d lc=%0d rc=%0d err=%0d code=%0d st=%0d exp dl=%0d dr=%0d done=%0d sl=%0d lc=%0d rc=%0d err=%0d code=%0d st=%0d",
                     tag, i, $time, dl, dr, dn, sl, lc, rc, er, cd, st,
                     edl, edr, m_done[i], m_sl[i], m_lc[i], m_rc[i], m_err[i], m_code[i], m_sticky[i]);
        end
    endtask

    task automatic expect_eq(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(logic [5:0] p, logic en, logic clr);
        {bus0.lc, bus0.lb, bus0.la, bus0.ra, bus0.rb, bus0.rc} = p;
        {bus1.lc, bus1.lb, bus1.la, bus1.ra, bus1.rb, bus1.rc} = p;
        bus0.sample_en = en; bus1.sample_en = en;
        bus0.clear     = clr; bus1.clear    = clr;
    endtask

    // Apply one sample across the rising edge, then compare both instances on the falling edge.
    task automatic step(logic [5:0] p, logic en, logic clr, string tag);
        drive(p, en, clr);
        @(posedge clk);
        model_step(0, p, en, clr);
        model_step(1, p, en, clr);
        @(negedge clk);
        check_model(0, tag);
        check_model(1, tag);
    endtask

    task automatic left_sweep(logic clr_last, string tag);
        step(6'b001000, 1'b1, 1'b0, tag);
        step(6'b011000, 1'b1, 1'b0, tag);
        step(6'b111000, 1'b1, 1'b0, tag);
        step(6'b000000, 1'b1, clr_last, tag);
    endtask

    logic [5:0] rp;
    logic [2:0] tv;
    int gside, gpos, r;

    initial begin
        drive(6'b000000, 1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_model(0, "reset");
        check_model(1, "reset");

        // Directed sequence: left sweep, 3 right sweeps, illegal, abort, skip, enable hold, clear.
        vecs.push_back(mk(6'b000000, 1, 0, 0, 0, 0, 0, 2'd0, 8'd0, 8'd0));
        vecs.push_back(mk(6'b001000, 1, 0, 1, 0, 0, 0, 2'd0, 8'd0, 8'd0));
        vecs.push_back(mk(6'b011000, 1, 0, 1, 0, 0, 0, 2'd0, 8'd0, 8'd0));
        vecs.push_back(mk(6'b111000, 1, 0, 1, 0, 0, 0, 2'd0, 8'd0, 8'd0));
        vecs.push_back(mk(6'b000000, 1, 0, 0, 0, 1, 0, 2'd0, 8'd1, 8'd0));
        for (int n = 1; n <= 3; n++) begin
            vecs.push_back(mk(6'b000100, 1, 0, 0, 1, 0, 0, 2'd0, 8'd1, 8'(n - 1)));
            vecs.push_back(mk(6'b000110, 1, 0, 0, 1, 0, 0, 2'd0, 8'd1, 8'(n - 1)));
            vecs.push_back(mk(6'b000111, 1, 0, 0, 1, 0, 0, 2'd0, 8'd1, 8'(n - 1)));
            vecs.push_back(mk(6'b000000, 1, 0, 0, 0, 1, 0, 2'd0, 8'd1, 8'(n)));
        end
        vecs.push_back(mk(6'b001001, 1, 0, 0, 0, 0, 1, 2'd1, 8'd1, 8'd3));
        vecs.push_back(mk(6'b000000, 1, 0, 0, 0, 0, 0, 2'd1, 8'd1, 8'd3));
        vecs.push_back(mk(6'b001000, 1, 0, 1, 0, 0, 0, 2'd1, 8'd1, 8'd3));
        vecs.push_back(mk(6'b000000, 1, 0, 0, 0, 0, 0, 2'd1, 8'd1, 8'd3));
        vecs.push_back(mk(6'b001000, 1, 0, 1, 0, 0, 0, 2'd1, 8'd1, 8'd3));
        vecs.push_back(mk(6'b111000, 1, 0, 0, 0, 0, 1, 2'd2, 8'd1, 8'd3));
        vecs.push_back(mk(6'b011000, 1, 0, 0, 0, 0, 0, 2'd2, 8'd1, 8'd3));
        vecs.push_back(mk(6'b000000, 1, 0, 0, 0, 0, 0, 2'd2, 8'd1, 8'd3));
        vecs.push_back(mk(6'b001000, 1, 0, 1, 0, 0, 0, 2'd2, 8'd1, 8'd3));
        for (int n = 0; n < 5; n++)
            vecs.push_back(mk(6'b111111, 0, 0, 1, 0, 0, 0, 2'd2, 8'd1, 8'd3));
        vecs.push_back(mk(6'b011000, 1, 0, 1, 0, 0, 0, 2'd2, 8'd1, 8'd3));
        vecs.push_back(mk(6'b111000, 1, 0, 1, 0, 0, 0, 2'd2, 8'd1, 8'd3));
        vecs.push_back(mk(6'b000000, 1, 1, 0, 0, 1, 0, 2'd2, 8'd0, 8'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].pat, vecs[i].en, vecs[i].clr, "table");
            checks++;
            if ({bus0.dir_left, bus0.dir_right, bus0.sweep_done, bus0.err, bus0.err_code,
                 bus0.left_count, bus0.right_count} ==
                {vecs[i].dl, vecs[i].dr, vecs[i].done, vecs[i].err, vecs[i].code,
                 vecs[i].lcnt, vecs[i].rcnt}) begin
                passed++;
            end else begin
                $display("FAIL table[%0d] got dl=%0b dr=%0b done=%0b err=%0b code=%0d lc=%0d rc=%0d exp dl=%0b dr=%0b done=%0b err=%0b code=%0d lc=%0d rc=%0d",
                         i, bus0.dir_left, bus0.dir_right, bus0.sweep_done, bus0.err, bus0.err_code,
                         bus0.left_count, bus0.right_count, vecs[i].dl, vecs[i].dr, vecs[i].done,
                         vecs[i].err, vecs[i].code, vecs[i].lcnt, vecs[i].rcnt);
            end
            if (i == 16) expect_eq("sweep_left_after_right", int'(bus0.sweep_left), 0);
            if (i == 20) begin
                expect_eq("abort_err_strict", int'(bus1.err), 1);
                expect_eq("abort_code_strict", int'(bus1.err_code), 3);
            end
        end

        // Saturation: five left sweeps on the 2-bit counter.
        for (int n = 0; n < 5; n++) left_sweep(1'b0, "sat");
        expect_eq("left_count_cw8", int'(bus0.left_count), 5);
        expect_eq("left_count_cw2_sat", int'(bus1.left_count), 3);

        // Clear on the same cycle as a completion.
        left_sweep(1'b1, "clr_done");
        expect_eq("clr_done_pulse", int'(bus0.sweep_done), 1);
        expect_eq("clr_done_count", int'(bus0.left_count), 0);
        expect_eq("clr_done_sticky", int'(bus1.err_sticky), 0);

        // Asynchronous reset in the middle of a sweep.
        step(6'b001000, 1'b1, 1'b0, "mid");
        step(6'b011000, 1'b1, 1'b0, "mid");
        step(6'b001001, 1'b1, 1'b0, "mid");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        expect_eq("async_reset_dut0", int'({bus0.dir_left, bus0.dir_right, bus0.sweep_done,
                  bus0.sweep_left, bus0.left_count, bus0.right_count, bus0.err, bus0.err_code,
                  bus0.err_sticky}), 0);
        check_model(1, "async_reset");
        @(negedge clk);
        reset = 1'b0;
        left_sweep(1'b0, "post_reset");
        expect_eq("post_reset_count", int'(bus0.left_count), 1);

        // Random traffic: mostly well-formed sweeps with injected faults, gaps, and clears.
        gside = 1; gpos = 0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            gpos = (gpos + 1) % 4;
            if (gpos == 0) gside = $urandom_range(1, 2);
            tv = 3'((1 << gpos) - 1);
            rp = (gside == 1) ? {tv, 3'b000} : {3'b000, tv[0], tv[1], tv[2]};
            if (r < 8)       rp = 6'($urandom);
            else if (r < 14) rp = 6'b000000;
            step(rp, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), "random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
